// File: rtl/cordic_cos_unit.sv
// Iterative CORDIC cosine of an IEEE-754 single angle (radians), Q4.20 core.
// Ports: clk, rst (sync, high), clk_en (level start/hold), angle_float in, result/done out.
module cordic_cos_unit #(
  parameter int FLOAT_DATA_WIDTH = 32,
  parameter int INTEGER_WIDTH    = 4,
  parameter int FRACTIONAL_WIDTH = 20,
  parameter int CORDIC_DEPTH     = 16,
  parameter int CONV_LATENCY     = 3,
  parameter int COUNTER_WIDTH    = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clk_en,
  input  logic [FLOAT_DATA_WIDTH-1:0] angle_float,
  output logic [FLOAT_DATA_WIDTH-1:0] result,
  output logic                        done
);

  localparam int DW  = INTEGER_WIDTH + FRACTIONAL_WIDTH;
  localparam int ITW = $clog2(CORDIC_DEPTH);

  localparam logic [DW-1:0] K_INIT   = DW'(24'h09B74F);
  localparam logic [DW-1:0] ONE_FIX  = DW'(1) << FRACTIONAL_WIDTH;
  localparam logic [31:0]   F_ONE    = 32'h3F800000;
  localparam logic [31:0]   F_RT2    = 32'h3F3504F3;
  localparam logic [31:0]   F_NAN    = 32'h7FC00000;
  localparam logic [30:0]   A_PI_4   = 31'h3F490FDB;
  localparam logic [30:0]   A_PI_2   = 31'h3FC90FDB;

  typedef enum logic [2:0] {
    IDLE,
    CONVERT,
    ITERATE,
    NORMALIZE,
    DONE
  } state_t;

  state_t                     state;
  logic [31:0]                angle_q;
  logic [COUNTER_WIDTH-1:0]   cnt;
  logic [ITW-1:0]             iter;
  logic signed [DW-1:0]       x, y, z;

  function automatic logic signed [DW-1:0] atan_lut(input logic [ITW-1:0] i);
    logic [23:0] v;
    case (int'(i))
      0:       v = 24'h0C90FE;
      1:       v = 24'h076B1A;
      2:       v = 24'h03EB6F;
      3:       v = 24'h01FD5C;
      4:       v = 24'h00FFAB;
      5:       v = 24'h007FF5;
      6:       v = 24'h003FFF;
      7:       v = 24'h002000;
      8:       v = 24'h001000;
      9:       v = 24'h000800;
      10:      v = 24'h000400;
      11:      v = 24'h000200;
      12:      v = 24'h000100;
      13:      v = 24'h000080;
      14:      v = 24'h000040;
      15:      v = 24'h000020;
      default: v = 24'h000000;
    endcase
    return DW'(v);
  endfunction

  // float -> Q4.20: {1,mant} carries 2^23 scale, so shift right by 130-exp.
  // Angles on this path are below 2.0, hence the shift is always >= 3.
  logic [7:0]           conv_sh;
  logic [23:0]          conv_mant;
  logic signed [DW-1:0] conv_fix;

  always_comb begin
    conv_mant = {1'b1, angle_q[22:0]};
    conv_sh   = 8'd130 - angle_q[30:23];
    conv_fix  = '0;
    if (conv_sh < 8'd24)
      conv_fix = DW'(conv_mant >> conv_sh);
  end

  // One rotation step; direction follows the sign of residual z.
  logic signed [DW-1:0] xs, ys, at;
  logic signed [DW-1:0] x_n, y_n, z_n;

  always_comb begin
    xs = x >>> iter;
    ys = y >>> iter;
    at = atan_lut(iter);
    if (!z[DW-1]) begin
      x_n = x - ys;
      y_n = y + xs;
      z_n = z - at;
    end else begin
      x_n = x + ys;
      y_n = y - xs;
      z_n = z + at;
    end
  end

  // Q4.20 -> float, truncating mantissa; x in (0,1) gives lead <= 19.
  logic [4:0]  lead;
  logic [31:0] wide;
  logic [31:0] norm_bits;

  always_comb begin
    lead = '0;
    for (int k = 0; k < DW; k++)
      if (x[k]) lead = k[4:0];
    wide = 32'(unsigned'(x)) << (5'd23 - lead);
    if (x[DW-1] || x == '0)
      norm_bits = 32'h0;
    else if (unsigned'(x) >= ONE_FIX)
      norm_bits = F_ONE;
    else
      norm_bits = {1'b0, 8'd107 + {3'b0, lead}, wide[22:0]};
  end

  logic [30:0] abs_in;
  logic [7:0]  exp_in;
  assign abs_in = angle_float[30:0];
  assign exp_in = angle_float[30:23];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      done    <= 1'b0;
      result  <= '0;
      angle_q <= '0;
      cnt     <= '0;
      iter    <= '0;
      x       <= '0;
      y       <= '0;
      z       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (clk_en) begin
            angle_q <= {1'b0, abs_in};
            if (exp_in == 8'h00) begin
              result <= F_ONE;
              state  <= DONE;
            end else if (abs_in == A_PI_4) begin
              result <= F_RT2;
              state  <= DONE;
            end else if (abs_in > A_PI_2 || exp_in == 8'hFF) begin
              result <= F_NAN;
              state  <= DONE;
            end else begin
              cnt   <= '0;
              state <= CONVERT;
            end
          end
        end
        CONVERT: begin
          if (cnt == COUNTER_WIDTH'(CONV_LATENCY - 1)) begin
            x     <= K_INIT;
            y     <= '0;
            z     <= conv_fix;
            iter  <= '0;
            state <= ITERATE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ITERATE: begin
          if (z == '0) begin
            state <= NORMALIZE;
          end else begin
            x <= x_n;
            y <= y_n;
            z <= z_n;
            if (iter == ITW'(CORDIC_DEPTH - 1))
              state <= NORMALIZE;
            else
              iter <= iter + 1'b1;
          end
        end
        NORMALIZE: begin
          result <= norm_bits;
          state  <= DONE;
        end
        DONE: begin
          if (clk_en) begin
            done <= 1'b1;
          end else begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_cos_unit.sv
// Directed scoreboard bench for cordic_cos_unit.
// Expected results are queued at start and checked when done rises.
module tb_cordic_cos_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_en;
  logic [31:0] angle_float;
  logic [31:0] result;
  logic        done;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [31:0] bits;
    real         ref_val;
    bit          approx;
  } exp_t;

  exp_t  sb[$];
  string tags[$];

  localparam real TOL = 1.0 / 16384.0;

  cordic_cos_unit dut (
    .clk         (clk),
    .rst         (rst),
    .clk_en      (clk_en),
    .angle_float (angle_float),
    .result      (result),
    .done        (done)
  );

  always #5 clk = ~clk;

  function automatic real f2r(input logic [31:0] b);
    real r;
    int  e;
    e = int'(b[30:23]);
    if (e == 0) return 0.0;
    r = (1.0 + real'(b[22:0]) / 8388608.0) * (2.0 ** (e - 127));
    return b[31] ? -r : r;
  endfunction

  task automatic check_bits(input string tag, input logic [31:0] obs,
                            input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [31:0] a, input string tag,
                        input logic [31:0] expv, input real rv,
                        input bit approx, input int budget,
                        input bit exact_lat);
    exp_t        e;
    string       t;
    int          n;
    bit          ok;
    logic [31:0] held;
    e.bits = expv;
    e.ref_val = rv;
    e.approx = approx;
    sb.push_back(e);
    tags.push_back(tag);
    angle_float = a;
    clk_en = 1'b1;
    tick();
    angle_float = ~a;
    n = 1;
    while (!done && n < budget + 2) begin
      tick();
      n++;
    end
    e = sb.pop_front();
    t = tags.pop_front();
    if (exact_lat)
      check_bits({t, "_lat"}, 32'(n), 32'(budget));
    else
      check_bits({t, "_lat"}, 32'(n <= budget), 32'd1);
    if (e.approx) begin
      ok = (f2r(result) - e.ref_val < TOL) && (e.ref_val - f2r(result) < TOL);
      compared++;
      assert (ok === 1'b1) else begin
        mismatched++;
        $error("FAIL %s: observed %h (%f) expected %f", t, result,
               f2r(result), e.ref_val);
      end
    end else begin
      check_bits(t, result, e.bits);
    end
    held = result;
    tick();
    tick();
    check_bits({t, "_hold_done"}, 32'(done), 32'd1);
    check_bits({t, "_hold_res"}, result, held);
    clk_en = 1'b0;
    tick();
    check_bits({t, "_drop"}, 32'(done), 32'd0);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    clk_en = 1'b0;
    angle_float = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();
    check_bits("rst_done", 32'(done), 32'd0);
    check_bits("rst_result", result, 32'h0);

    run_op(32'h00000000, "zero", 32'h3F800000, 0.0, 1'b0, 2, 1'b1);
    run_op(32'h80000001, "neg_denorm", 32'h3F800000, 0.0, 1'b0, 2, 1'b1);
    run_op(32'h3F490FDB, "pi_4", 32'h3F3504F3, 0.0, 1'b0, 2, 1'b1);
    run_op(32'h40000000, "two", 32'h7FC00000, 0.0, 1'b0, 2, 1'b1);
    run_op(32'h7F800000, "inf", 32'h7FC00000, 0.0, 1'b0, 2, 1'b1);
    run_op(32'h3F060A92, "pi_6", 32'h0, 0.8660254, 1'b1, 22, 1'b0);
    run_op(32'h3F860A92, "pi_3", 32'h0, 0.5, 1'b1, 22, 1'b0);
    run_op(32'hBF860A92, "neg_pi_3", 32'h0, 0.5, 1'b1, 22, 1'b0);
    run_op(32'h3FC90FDB, "pi_2", 32'h0, 0.0, 1'b1, 22, 1'b0);
    run_op(32'h3F000000, "half", 32'h0, 0.8775826, 1'b1, 22, 1'b0);

    angle_float = 32'h3F860A92;
    clk_en = 1'b1;
    repeat (8) tick();
    rst = 1'b1;
    tick();
    check_bits("midrst_done", 32'(done), 32'd0);
    check_bits("midrst_result", result, 32'h0);
    rst = 1'b0;
    clk_en = 1'b0;
    tick();
    run_op(32'h3F860A92, "after_rst", 32'h0, 0.5, 1'b1, 22, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
